// File: rtl/wrr_grant_arbiter_if.sv
// Request/grant bundle between the requesting channels (master) and the
// weighted round-robin arbiter (slave) that drives the channel MUX select.
interface wrr_grant_arbiter_if #(
  parameter int CHANNELS = 8,
  parameter int WT_WIDTH = 4,
  parameter int ID_WIDTH = 3
);
  logic [CHANNELS-1:0]          req;
  logic [CHANNELS*WT_WIDTH-1:0] weightBus;
  logic                         beat;
  logic [CHANNELS-1:0]          grantOneHot;
  logic                         grantValid;
  logic [ID_WIDTH-1:0]          grantId;

  modport master (
    output req, weightBus, beat,
    input  grantOneHot, grantValid, grantId
  );

  modport slave (
    input  req, weightBus, beat,
    output grantOneHot, grantValid, grantId
  );
endinterface

// File: rtl/wrr_grant_arbiter.sv
// Weighted round-robin arbiter: a granted channel keeps the grant for up to its
// weight in beats, then the grant rotates to the next requester in circular order.
module wrr_grant_arbiter #(
  parameter int CHANNELS = 8,
  parameter int WT_WIDTH = 4,
  parameter int ID_WIDTH = 3
) (
  input logic                clk,
  input logic                reset,
  wrr_grant_arbiter_if.slave bus
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]          state_q,  state_d;
  logic [IDX_W-1:0]    ptr_q,    ptr_d;
  logic [IDX_W-1:0]    cur_q,    cur_d;
  logic [WT_WIDTH-1:0] credit_q, credit_d;
  logic [CHANNELS-1:0] grant_q,  grant_d;
  logic                valid_q,  valid_d;
  logic [ID_WIDTH-1:0] id_q,     id_d;

  logic [WT_WIDTH-1:0] weight [CHANNELS];
  logic [IDX_W-1:0]    next_ptr;
  logic [IDX_W-1:0]    search_start;
  logic [IDX_W-1:0]    sel_idx;
  logic                found;
  logic                end_of_grant;
  logic                load_grant;
  logic [WT_WIDTH-1:0] sel_weight;
  logic [WT_WIDTH-1:0] load_credit;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_weight
    assign weight[gi] = bus.weightBus[gi*WT_WIDTH +: WT_WIDTH];
  end

  assign next_ptr     = (cur_q == IDX_W'(CHANNELS - 1)) ? '0 : cur_q + 1'b1;
  // When a grant ends, the search already starts past the current holder.
  assign search_start = (state_q == ST_GRANT) ? next_ptr : ptr_q;

  // Circular priority search; scanning offsets downwards lets the nearest win.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      int idx;
      idx = int'(search_start) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (bus.req[IDX_W'(idx)]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(idx);
      end
    end
  end

  assign sel_weight   = weight[sel_idx];
  assign load_credit  = (sel_weight == '0) ? WT_WIDTH'(1) : sel_weight;
  assign end_of_grant = (bus.beat && (credit_q == WT_WIDTH'(1))) || !bus.req[cur_q];
  assign load_grant   = found && ((state_q == ST_IDLE) || end_of_grant);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    id_d     = id_q;

    if (state_q == ST_GRANT) begin
      if (end_of_grant) begin
        ptr_d = next_ptr;
        if (!found) begin
          state_d  = ST_IDLE;
          credit_d = '0;
          grant_d  = '0;
          valid_d  = 1'b0;
          id_d     = '0;
        end
      end else if (bus.beat) begin
        credit_d = credit_q - 1'b1;
      end
    end

    if (load_grant) begin
      state_d          = ST_GRANT;
      cur_d            = sel_idx;
      credit_d         = load_credit;
      grant_d          = '0;
      grant_d[sel_idx] = 1'b1;
      valid_d          = 1'b1;
      id_d             = ID_WIDTH'(sel_idx);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cur_q    <= '0;
      credit_q <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
    end
  end

  assign bus.grantOneHot = grant_q;
  assign bus.grantValid  = valid_q;
  assign bus.grantId     = id_q;

endmodule

// File: tb/tb_wrr_grant_arbiter.sv
// Scoreboard bench: a queue-based arbitration model predicts every cycle's grant,
// and an independent monitor compares the arbiter outputs against it.
module tb_wrr_grant_arbiter;

  localparam int CH = 8;
  localparam int WW = 4;
  localparam int IW = 3;

  typedef struct {
    logic [CH-1:0] g;
    logic          v;
    logic [IW-1:0] id;
  } exp_t;

  logic clk;
  logic reset;

  wrr_grant_arbiter_if #(.CHANNELS(CH), .WT_WIDTH(WW), .ID_WIDTH(IW)) bus ();

  wrr_grant_arbiter #(.CHANNELS(CH), .WT_WIDTH(WW), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  exp_t          exp_q [$];
  logic [CH-1:0] seen  [$];
  logic [CH-1:0] want  [$];
  logic [WW-1:0] w     [CH];

  // Model: holder index (-1 when idle), rotation pointer, remaining beats.
  int m_cur;
  int m_ptr;
  int m_credit;

  function automatic int find_req(logic [CH-1:0] r, int start);
    for (int k = 0; k < CH; k++) begin
      if (r[(start + k) % CH]) return (start + k) % CH;
    end
    return -1;
  endfunction

  function automatic int credit_of(int ch);
    return (w[ch] == 0) ? 1 : int'(w[ch]);
  endfunction

  task automatic model_cycle(input logic [CH-1:0] r, input logic b, input logic rs);
    int f;
    exp_t e;
    if (rs) begin
      m_cur = -1; m_ptr = 0; m_credit = 0;
    end else if (m_cur < 0) begin
      f = find_req(r, m_ptr);
      if (f >= 0) begin m_cur = f; m_credit = credit_of(f); end
    end else if (!r[m_cur] || (b && m_credit == 1)) begin
      m_ptr = (m_cur + 1) % CH;
      f = find_req(r, m_ptr);
      if (f >= 0) begin m_cur = f; m_credit = credit_of(f); end
      else m_cur = -1;
    end else if (b) begin
      m_credit = m_credit - 1;
    end
    e.g  = (m_cur < 0) ? '0 : (CH'(1) << m_cur);
    e.v  = (m_cur >= 0);
    e.id = (m_cur < 0) ? '0 : IW'(m_cur);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [CH-1:0] r, input logic b, input logic rs);
    @(negedge clk);
    reset   = rs;
    bus.req = r;
    bus.beat = b;
    for (int i = 0; i < CH; i++) bus.weightBus[i*WW +: WW] = w[i];
    model_cycle(r, b, rs);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) return;
    end
    tests++; fails++;
    $display("FAIL drain: %0d expected grants never observed, required 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic check_seq(input string name);
    tests++;
    if (seen.size() != want.size()) begin
      fails++;
      $display("FAIL %s: observed %0d grants, required %0d", name, seen.size(), want.size());
      return;
    end
    for (int i = 0; i < want.size(); i++) begin
      if (seen[i] !== want[i]) begin
        fails++;
        $display("FAIL %s: cycle %0d grant %h, required %h", name, i, seen[i], want[i]);
        return;
      end
    end
  endtask

  // Monitor: outputs are presented every cycle, so one expectation is popped per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        seen.push_back(bus.grantOneHot);
        tests++;
        if (bus.grantOneHot !== e.g || bus.grantValid !== e.v || bus.grantId !== e.id) begin
          fails++;
          $display("FAIL grant: got oh=%h v=%b id=%0d, required oh=%h v=%b id=%0d",
                   bus.grantOneHot, bus.grantValid, bus.grantId, e.g, e.v, e.id);
        end
        tests++;
        if ($countones(bus.grantOneHot) > 1 || bus.grantValid !== (bus.grantOneHot != 0)) begin
          fails++;
          $display("FAIL onehot: oh=%h v=%b, required one-hot consistent with valid",
                   bus.grantOneHot, bus.grantValid);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.beat = 1'b0;
    bus.weightBus = '0;
    for (int i = 0; i < CH; i++) w[i] = WW'(i + 1);
    m_cur = -1; m_ptr = 0; m_credit = 0;

    step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b0);
    drain();

    // 1: async reset mid-grant, then re-grant one cycle after release
    step(8'h20, 1'b0, 1'b0);
    step(8'h20, 1'b0, 1'b0);
    drain();
    #3 reset = 1'b1;
    #1;
    tests++;
    if (bus.grantOneHot !== '0 || bus.grantValid !== 1'b0 || bus.grantId !== '0) begin
      fails++;
      $display("FAIL async_reset: got oh=%h v=%b id=%0d, required all zero",
               bus.grantOneHot, bus.grantValid, bus.grantId);
    end
    step(8'h20, 1'b0, 1'b1);
    step(8'h20, 1'b0, 1'b0);
    drain();
    tests++;
    if (bus.grantOneHot !== 8'h20) begin
      fails++;
      $display("FAIL reset_release: got %h, required 20", bus.grantOneHot);
    end

    // 2: sole requester re-granted every 3 beats with no bubble
    step('0, 1'b0, 1'b1);
    w[2] = 4'd3;
    drain(); seen.delete(); want.delete();
    for (int i = 0; i < 8; i++) begin step(8'h04, 1'b1, 1'b0); want.push_back(8'h04); end
    drain();
    check_seq("self_regrant");

    // 3: weights 2 and 1 alternate
    step('0, 1'b0, 1'b1);
    w[0] = 4'd2; w[3] = 4'd1;
    drain(); seen.delete(); want.delete();
    for (int i = 0; i < 6; i++) step(8'h09, 1'b1, 1'b0);
    want = '{8'h01, 8'h01, 8'h08, 8'h01, 8'h01, 8'h08};
    drain();
    check_seq("weighted_pair");

    // 4: zero weights act as one, pointer wraps 7 -> 0
    step('0, 1'b0, 1'b1);
    w[6] = 4'd1; w[7] = 4'd0; w[0] = 4'd0;
    drain(); seen.delete(); want.delete();
    step(8'h40, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h81, 1'b1, 1'b0);
    want = '{8'h40, 8'h80, 8'h01, 8'h80};
    drain();
    check_seq("wrap_zero_wt");

    // 5: request withdrawn mid-grant, with and without another requester
    step('0, 1'b0, 1'b1);
    w[1] = 4'd4; w[6] = 4'd2;
    step(8'h42, 1'b0, 1'b0);
    step(8'h42, 1'b1, 1'b0);
    step(8'h42, 1'b1, 1'b0);
    step(8'h40, 1'b0, 1'b0);
    step(8'h40, 1'b1, 1'b0);
    step(8'h40, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    step(8'h02, 1'b0, 1'b0);
    step(8'h02, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);

    // 6: no beats means the grant is held; then w4 beats end it
    w[4] = 4'd5;
    for (int i = 0; i < 12; i++) step(8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(8'h18, 1'b1, 1'b0);
    step(8'h18, 1'b0, 1'b0);
    drain();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [CH-1:0] r;
      if ($urandom_range(0, 19) == 0) w[$urandom_range(0, CH-1)] = WW'($urandom);
      r = CH'($urandom) & CH'($urandom);
      if ($urandom_range(0, 9) == 0) r = '0;
      step(r, ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
